pipe_hazard_ctrl: RTL



---
 rtl/pipe_hazard_ctrl_if.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the datapath and pipe_hazard_ctrl.
// The datapath (master) presents hazard sources and consumes stall/flush
// controls. The controller (slave) does the reverse.
interface pipe_hazard_ctrl_if;
  logic [4:0] ID_rs;
  logic [4:0] ID_rt;
  logic       ID_UsesRt;
  logic       EX_MemRead;
  logic [4:0] EX_rt;
  logic       EX_MduStart;
  logic       ID_Redirect;
  logic       IF_InstrValid;

  logic       PC_WR;
  logic       IF_ID_WR;
  logic       ID_IFFlush;
  logic       ID_EX_Bubble;
  logic       ID_EX_WR;
  logic       EX_MEM_Bubble;
  logic       MduBusy;

  modport master (
    output ID_rs, ID_rt, ID_UsesRt, EX_MemRead, EX_rt, EX_MduStart,
           ID_Redirect, IF_InstrValid,
    input  PC_WR, IF_ID_WR, ID_IFFlush, ID_EX_Bubble, ID_EX_WR,
           EX_MEM_Bubble, MduBusy
  );

  modport slave (
    input  ID_rs, ID_rt, ID_UsesRt, EX_MemRead, EX_rt, EX_MduStart,
           ID_Redirect, IF_InstrValid,
    output PC_WR, IF_ID_WR, ID_IFFlush, ID_EX_Bubble, ID_EX_WR,
           EX_MEM_Bubble, MduBusy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use stall, MDU
// occupancy, instruction-fetch wait and branch/jump redirect.
// Optional macro HAZ_FETCH_WAIT_EN enables the FETCH_WAIT state and the use
// of IF_InstrValid. Without it, fetch is treated as always valid.
// All outputs are combinational from state and inputs.
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
`ifdef HAZ_FETCH_WAIT_EN
    FETCH_WAIT = 2'd2,
`endif
    MDU_BUSY   = 2'd1
  } state_t;

  typedef struct packed {
    logic pc_wr;
    logic ifid_wr;
    logic flush_n;
    logic idex_bub;
    logic idex_wr;
    logic exmem_bub;
    logic busy;
  } ctrl_t;

  state_t           state;
  logic [CNT_W-1:0] mdu_cnt;
  ctrl_t            ctl;
  logic             lu;
  logic             valid;
  logic             waiting;

  // Load-use: the load in EX writes a register the ID instruction reads.
  assign lu = bus.EX_MemRead && (bus.EX_rt != 5'd0) &&
              ((bus.EX_rt == bus.ID_rs) ||
               (bus.ID_UsesRt && (bus.EX_rt == bus.ID_rt)));

`ifdef HAZ_FETCH_WAIT_EN
  assign valid   = bus.IF_InstrValid;
  // Inside an ongoing fetch wait the bubble in ID cannot stall on a load.
  assign waiting = (state == FETCH_WAIT) && !bus.IF_InstrValid;
`else
  logic unused_instr_valid;
  assign unused_instr_valid = bus.IF_InstrValid;
  assign valid   = 1'b1;
  assign waiting = 1'b0;
`endif

  // Control decode: MDU hold > load-use stall > fetch bubble/redirect > run.
  always_comb begin
    ctl = '{pc_wr: 1'b1, ifid_wr: 1'b1, flush_n: 1'b1, idex_bub: 1'b0,
            idex_wr: 1'b1, exmem_bub: 1'b0, busy: 1'b0};
    if (state == MDU_BUSY) begin
      ctl.pc_wr     = 1'b0;
      ctl.ifid_wr   = 1'b0;
      ctl.idex_wr   = 1'b0;
      ctl.exmem_bub = 1'b1;
      ctl.busy      = 1'b1;
    end else if (lu && !waiting) begin
      // Redirect is dropped here; the branch re-resolves after the stall.
      ctl.pc_wr    = 1'b0;
      ctl.ifid_wr  = 1'b0;
      ctl.idex_bub = 1'b1;
    end else if (!valid || bus.ID_Redirect) begin
      // Clear IF/ID; the PC only moves when there is a redirect target.
      ctl.pc_wr   = bus.ID_Redirect;
      ctl.flush_n = 1'b0;
    end
    // A flush must always be written into IF/ID.
    if (!ctl.flush_n) ctl.ifid_wr = 1'b1;
  end

  assign bus.PC_WR         = ctl.pc_wr;
  assign bus.IF_ID_WR      = ctl.ifid_wr;
  assign bus.ID_IFFlush    = ctl.flush_n;
  assign bus.ID_EX_Bubble  = ctl.idex_bub;
  assign bus.ID_EX_WR      = ctl.idex_wr;
  assign bus.EX_MEM_Bubble = ctl.exmem_bub;
  assign bus.MduBusy       = ctl.busy;

  // State and MDU occupancy counter; an MDU start wins over fetch wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      mdu_cnt <= '0;
    end else if (state == MDU_BUSY) begin
      if (mdu_cnt == '0) state   <= RUN;
      else               mdu_cnt <= mdu_cnt - CNT_ONE;
    end else if (bus.EX_MduStart) begin
      state   <= MDU_BUSY;
      mdu_cnt <= CNT_LOAD;
`ifdef HAZ_FETCH_WAIT_EN
    end else if (!valid && (waiting || !lu)) begin
      state <= FETCH_WAIT;
`endif
    end else begin
      state <= RUN;
    end
  end

endmodule
